pixel_sequencer: RTL and testbench
==================================

# pixel_sequencer

Synthesizable initiator for the pixel-processing handshake. Reads 24-bit RGB pixels from a source BRAM and presents each one to `process` on `Rin/Gin/Bin` with `OKin`. It waits for `OKout`, then writes `{Rout,Gout,Bout}` to a destination BRAM. It replaces the simulation-only BRAM-to-`process` driver, so whole-image operations run in hardware and the result lands in memory instead of a `.coe` file.

## Interface
- `NPIX`, 200000: pixels per frame, range 1..2^ADDR_W.
- `ADDR_W`, 18: BRAM address width.
- `SRC_BASE`, 0: first source address.
- `DST_BASE`, 0: first destination address.
- `RD_LAT`, 1: source BRAM read latency in cycles, 1..3.
- `TIMEOUT_CYC`, 1024: watchdog limit. Used only with `PIXSEQ_TIMEOUT_EN`.

Ports:
- `clka` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a frame. Sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last pixel is written.
- `err` out 1: sticky timeout flag. Cleared by `reset` or an accepted `start`.
- `src_en` out 1: source BRAM enable.
- `src_addr` out ADDR_W: source address.
- `src_dout` in 24: source read data, `{R,G,B}`.
- `Rin`, `Gin`, `Bin` out 8 each: pixel to `process`.
- `OKin` out 1: request to `process`.
- `Rout`, `Gout`, `Bout` in 8 each: result from `process`.
- `OKout` in 1: result-valid from `process`.
- `dst_en` out 1: destination BRAM enable.
- `dst_we` out 1: destination BRAM write enable.
- `dst_addr` out ADDR_W: destination address.
- `dst_din` out 24: write data, `{Rout,Gout,Bout}`.

## Operation
- All outputs are registered.
- Reset forces state IDLE and clears the pixel index. Every output resets to 0: `busy`, `done`, `err`, `src_en`, `src_addr`, `Rin/Gin/Bin`, `OKin`, `dst_en/we/addr/din`.
- States: IDLE, RD, RDW, REQ, WR, REL, FIN.
- IDLE: `start`=1 sets `idx`=0, clears `err`, goes to RD.
- RD: one cycle. `src_en`=1, `src_addr`=SRC_BASE+idx. Goes to RDW.
- RDW: waits RD_LAT cycles. On the last one, latches `src_dout` into `{Rin,Gin,Bin}` and goes to REQ.
- REQ: `OKin`=1, and `Rin/Gin/Bin` are held stable. When `OKout`=1 is sampled, captures `{Rout,Gout,Bout}` into `dst_din`, drops `OKin`, and goes to WR.
- WR: one cycle. `dst_en`=`dst_we`=1, `dst_addr`=DST_BASE+idx.
  - If idx==NPIX-1, go to FIN.
  - Otherwise increment idx and go to REL.
- REL: `OKin`=0. Stays until `OKout`=0 is sampled, then goes to RD. This is a four-phase handshake.
- FIN: pulses `done` for one cycle, returns to IDLE.
- `OKout` in any state other than REQ or REL is ignored.
- `start` while `busy`=1 is ignored.
- Address arithmetic is modulo 2^ADDR_W; a base plus index past the top wraps silently.
- Reset asserted mid-frame aborts immediately: no write, `OKin` drops on the next edge, no `done` pulse.

## Timing
- IDLE to first `OKin`: 2+RD_LAT cycles after the `start` edge.
- Per pixel, with `process` raising `OKout` k cycles after seeing `OKin` and dropping it 1 cycle after `OKin` falls: 1 (RD) + RD_LAT (RDW) + (k+1) (REQ) + 1 (WR) + 1 (REL). That is k+4+RD_LAT cycles.
- The last pixel skips REL and goes straight to FIN.
- `done` asserts exactly one cycle after the final WR cycle.
- `dst_we` is high for exactly one cycle per pixel, for NPIX pulses per frame.

## Configuration
- Macro: `PIXSEQ_TIMEOUT_EN`.
- Defined:
  - A counter runs in REQ. If `OKout` is not seen within TIMEOUT_CYC cycles, the sequencer sets `err`=1.
  - It then writes 24'h000000 for that pixel and proceeds as normal through WR/REL.
  - REL also times out after TIMEOUT_CYC cycles, setting `err` and continuing.
- Not defined:
  - No counter is built, and `err` is tied to 0.
  - REQ and REL wait indefinitely.

## Test plan
- NPIX=4, RD_LAT=1, stub inverter with k=2. Source holds 0x102030, 0x000000, 0xFFFFFF, 0x7F80AA. Required: the destination holds 0xEFDFCF, 0xFFFFFF, 0x000000, 0x807F55, with 4 `dst_we` pulses and `done` once, 29 cycles after `start`.
- RD_LAT=2 with the same data. Required: identical destination contents, and each pixel takes one cycle longer than in the RD_LAT=1 case.
- `start` pulsed again during pixel 1. Required: it is ignored, the frame completes normally, and only 4 writes occur.
- `reset` asserted while in REQ for pixel 2. Required: all outputs are 0 next cycle, no write for pixel 2, no `done`. A fresh `start` then re-runs from address SRC_BASE.
- Stub holds `OKout`=1 for 3 cycles after `OKin` falls. Required: the sequencer stays in REL, and the next `src_en` occurs only after `OKout`=0 is sampled.
- With `PIXSEQ_TIMEOUT_EN` and TIMEOUT_CYC=16, stub never responds for pixel 1. Required: `err`=1, and 0x000000 is written at DST_BASE+1.
  - Remaining pixels are processed normally, and `done` pulses.

Source files
------------

// File: rtl/pixel_sequencer.sv
// pixel_sequencer: streams source-BRAM pixels through process into a destination BRAM; PIXSEQ_TIMEOUT_EN adds a handshake watchdog
module pixel_sequencer #(
  parameter int NPIX        = 200000,
  parameter int ADDR_W      = 18,
  parameter int SRC_BASE    = 0,
  parameter int DST_BASE    = 0,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [23:0]       src_dout,
  output logic [7:0]        Rin,
  output logic [7:0]        Gin,
  output logic [7:0]        Bin,
  output logic              OKin,
  input  logic [7:0]        Rout,
  input  logic [7:0]        Gout,
  input  logic [7:0]        Bout,
  input  logic              OKout,
  output logic              dst_en,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [23:0]       dst_din
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RDW  = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_REL  = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;
  localparam int CW = $clog2((TIMEOUT_CYC > RD_LAT ? TIMEOUT_CYC : RD_LAT) + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [23:0]       pix_q, pix_d;
  logic [23:0]       dst_din_q, dst_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              src_en_q, src_en_d;
  logic              okin_q, okin_d;
  logic              dst_en_q, dst_en_d;
  logic              dst_we_q, dst_we_d;
  logic              tmo;
`ifdef PIXSEQ_TIMEOUT_EN
  assign tmo = cnt_q == CW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  // next-state logic; outputs are decoded from the next state so they line up with the state they belong to
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pix_d     = pix_q;
    dst_din_d = dst_din_q;
    case (state_q)
      S_IDLE: if (start) begin
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = S_RD;
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = S_RDW;
      end
      S_RDW: if (cnt_q == CW'(RD_LAT - 1)) begin
        pix_d   = src_dout;
        cnt_d   = '0;
        state_d = S_REQ;
      end else cnt_d = cnt_q + 1'b1;
      S_REQ: if (OKout) begin
        dst_din_d = {Rout, Gout, Bout};
        state_d   = S_WR;
      end else if (tmo) begin
        err_d     = 1'b1;
        dst_din_d = '0;
        state_d   = S_WR;
      end else cnt_d = cnt_q + 1'b1;
      S_WR: begin
        cnt_d = '0;
        if (idx_q == LAST_IDX) state_d = S_FIN;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_REL;
        end
      end
      S_REL: if (!OKout) state_d = S_RD;
      else if (tmo) begin
        err_d   = 1'b1;
        state_d = S_RD;
      end else cnt_d = cnt_q + 1'b1;
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d     = state_d != S_IDLE;
    done_d     = state_q == S_FIN;
    src_en_d   = state_d == S_RD;
    okin_d     = state_d == S_REQ;
    dst_en_d   = state_d == S_WR;
    dst_we_d   = state_d == S_WR;
    src_addr_d = state_d == S_RD ? ADDR_W'(SRC_BASE) + idx_d : src_addr_q;
    dst_addr_d = state_d == S_WR ? ADDR_W'(DST_BASE) + idx_q : dst_addr_q;
  end
  // state and registered outputs, all cleared by reset
  always_ff @(posedge clka) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
      dst_din_q  <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      src_en_q   <= 1'b0;
      okin_q     <= 1'b0;
      dst_en_q   <= 1'b0;
      dst_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      dst_din_q  <= dst_din_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      src_en_q   <= src_en_d;
      okin_q     <= okin_d;
      dst_en_q   <= dst_en_d;
      dst_we_q   <= dst_we_d;
    end
  end
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign src_en          = src_en_q;
  assign src_addr        = src_addr_q;
  assign {Rin, Gin, Bin} = pix_q;
  assign OKin            = okin_q;
  assign dst_en          = dst_en_q;
  assign dst_we          = dst_we_q;
  assign dst_addr        = dst_addr_q;
  assign dst_din         = dst_din_q;
endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer: directed bench with BRAM models and an inverting process stub, RD_LAT=1 and RD_LAT=2 instances
module tb_pixel_sequencer;
  localparam int AW = 4;
  localparam int NP = 4;
  localparam int SB = 3;
  localparam int DB = 14;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int cyc = 0;
  int hold = 0;
  int mute = -1;
  int n_tests = 0;
  int n_fail = 0;
  logic [23:0] src_mem [16];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : gi
    logic busy, done, err, src_en, OKin, OKout, dst_en, dst_we;
    logic [AW-1:0] src_addr, dst_addr;
    logic [23:0] src_dout, dst_din, rd1, rd2;
    logic [7:0] Rin, Gin, Bin, Rout, Gout, Bout;
    logic [23:0] dst_mem [16];
    logic [AW-1:0] last_wr = '0;
    int we_cnt = 0;
    int done_cnt = 0;
    int done_at = 0;
    int kcnt = 0;
    int hcnt = 0;
    int nreq = 0;
    logic okin_p = 1'b0;
    pixel_sequencer #(.NPIX(NP), .ADDR_W(AW), .SRC_BASE(SB), .DST_BASE(DB), .RD_LAT(g + 1), .TIMEOUT_CYC(TO)) u_dut (
      .clka(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
      .src_en(src_en), .src_addr(src_addr), .src_dout(src_dout),
      .Rin(Rin), .Gin(Gin), .Bin(Bin), .OKin(OKin),
      .Rout(Rout), .Gout(Gout), .Bout(Bout), .OKout(OKout),
      .dst_en(dst_en), .dst_we(dst_we), .dst_addr(dst_addr), .dst_din(dst_din)
    );
    assign src_dout = g == 0 ? rd1 : rd2;
    always @(posedge clk) begin
      if (src_en) rd1 <= src_mem[src_addr];
      rd2 <= rd1;
      if (dst_en && dst_we) begin
        dst_mem[dst_addr] <= dst_din;
        we_cnt <= we_cnt + 1;
        last_wr <= dst_addr;
      end
    end
    always @(posedge clk) begin
      if (reset) begin
        OKout <= 1'b0;
        kcnt <= 0;
        hcnt <= 0;
        nreq <= 0;
        okin_p <= 1'b0;
      end else begin
        okin_p <= OKin;
        if (!OKin && okin_p) nreq <= nreq + 1;
        if (OKin && !OKout && nreq != mute) begin
          if (kcnt == 1) begin
            OKout <= 1'b1;
            {Rout, Gout, Bout} <= ~{Rin, Gin, Bin};
            kcnt <= 0;
            hcnt <= 0;
          end else kcnt <= kcnt + 1;
        end
        if (!OKin && OKout) begin
          if (hcnt == hold) OKout <= 1'b0;
          else hcnt <= hcnt + 1;
        end
      end
    end
    always @(negedge clk) if (done) begin
      done_cnt <= done_cnt + 1;
      done_at <= cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int t0, d0, d1, w0, w1;
    logic [23:0] exp_px [4];
    exp_px[0] = 24'hEFDFCF;
    exp_px[1] = 24'hFFFFFF;
    exp_px[2] = 24'h000000;
    exp_px[3] = 24'h807F55;
    src_mem[3] = 24'h102030;
    src_mem[4] = 24'h000000;
    src_mem[5] = 24'hFFFFFF;
    src_mem[6] = 24'h7F80AA;
    tick(3);
    chk("rst_ctrl", {gi[0].busy, gi[0].done, gi[0].err, gi[0].src_en, gi[0].OKin, gi[0].dst_en, gi[0].dst_we}, 0);
    chk("rst_src_addr", gi[0].src_addr, 0);
    chk("rst_pix", {gi[0].Rin, gi[0].Gin, gi[0].Bin}, 0);
    chk("rst_dst_addr", gi[0].dst_addr, 0);
    chk("rst_dst_din", gi[0].dst_din, 0);
    reset = 1'b0;
    tick(1);
    start = 1'b1;
    t0 = cyc;
    d0 = gi[0].done_cnt;
    d1 = gi[1].done_cnt;
    w0 = gi[0].we_cnt;
    w1 = gi[1].we_cnt;
    tick(1);
    start = 1'b0;
    chk("f1_busy", gi[0].busy, 1);
    chk("f1_src_en", gi[0].src_en, 1);
    chk("f1_src_addr0", gi[0].src_addr, SB);
    tick(1);
    chk("f1_okin_early", gi[0].OKin, 0);
    tick(1);
    chk("f1_okin_lat1", gi[0].OKin, 1);
    chk("f1_okin_lat2_early", gi[1].OKin, 0);
    chk("f1_rin", {gi[0].Rin, gi[0].Gin, gi[0].Bin}, 24'h102030);
    tick(1);
    chk("f1_okin_lat2", gi[1].OKin, 1);
    tick(6);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(39);
    chk("f1_done_time_lat1", gi[0].done_at - t0, 29);
    chk("f1_done_time_lat2", gi[1].done_at - t0, 33);
    chk("f1_done_once_lat1", gi[0].done_cnt - d0, 1);
    chk("f1_done_once_lat2", gi[1].done_cnt - d1, 1);
    chk("f1_writes_lat1", gi[0].we_cnt - w0, 4);
    chk("f1_writes_lat2", gi[1].we_cnt - w1, 4);
    chk("f1_idle", gi[0].busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f1_dst_lat1_%0d", i), gi[0].dst_mem[(DB + i) % 16], exp_px[i]);
      chk($sformatf("f1_dst_lat2_%0d", i), gi[1].dst_mem[(DB + i) % 16], exp_px[i]);
    end
    start = 1'b1;
    t0 = cyc;
    d0 = gi[0].done_cnt;
    w0 = gi[0].we_cnt;
    tick(1);
    start = 1'b0;
    tick(16);
    chk("ab_in_req", gi[0].OKin, 1);
    chk("ab_src_addr2", gi[0].src_addr, SB + 2);
    reset = 1'b1;
    tick(1);
    chk("ab_ctrl", {gi[0].busy, gi[0].done, gi[0].err, gi[0].src_en, gi[0].OKin, gi[0].dst_en, gi[0].dst_we}, 0);
    chk("ab_pix", {gi[0].Rin, gi[0].Gin, gi[0].Bin}, 0);
    chk("ab_dst_din", gi[0].dst_din, 0);
    chk("ab_src_addr", gi[0].src_addr, 0);
    reset = 1'b0;
    tick(15);
    chk("ab_writes", gi[0].we_cnt - w0, 2);
    chk("ab_last_wr", gi[0].last_wr, (DB + 1) % 16);
    chk("ab_no_done", gi[0].done_cnt - d0, 0);
    start = 1'b1;
    d0 = gi[0].done_cnt;
    w0 = gi[0].we_cnt;
    tick(1);
    start = 1'b0;
    chk("rs_src_en", gi[0].src_en, 1);
    chk("rs_src_addr", gi[0].src_addr, SB);
    tick(40);
    chk("rs_done", gi[0].done_cnt - d0, 1);
    chk("rs_writes", gi[0].we_cnt - w0, 4);
    hold = 3;
    start = 1'b1;
    t0 = cyc;
    tick(1);
    start = 1'b0;
    tick(7);
    chk("hold_no_rd", gi[0].src_en, 0);
    chk("hold_okin_low", gi[0].OKin, 0);
    chk("hold_busy", gi[0].busy, 1);
    tick(3);
    chk("hold_rd", gi[0].src_en, 1);
    chk("hold_src_addr1", gi[0].src_addr, SB + 1);
    tick(40);
    chk("hold_done_time", gi[0].done_at - t0, 38);
    hold = 0;
`ifdef PIXSEQ_TIMEOUT_EN
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    mute = 1;
    start = 1'b1;
    d0 = gi[0].done_cnt;
    tick(1);
    start = 1'b0;
    tick(120);
    chk("to_err", gi[0].err, 1);
    chk("to_zero_wr", gi[0].dst_mem[(DB + 1) % 16], 24'h000000);
    chk("to_px0", gi[0].dst_mem[DB % 16], exp_px[0]);
    chk("to_px3", gi[0].dst_mem[(DB + 3) % 16], exp_px[3]);
    chk("to_done", gi[0].done_cnt - d0, 1);
    mute = -1;
`else
    chk("no_err", gi[0].err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
